// File: rtl/psum_ofifo_pkg.sv
// Shared helpers for the PE-array output collector: pointer sizing, ReLU and column slicing.
package psum_ofifo_pkg;

    localparam int PSUM_BW = 16;

    typedef logic [PSUM_BW-1:0] psum_t;

    // One extra bit above the address distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic psum_t relu(input psum_t v);
        return v[PSUM_BW-1] ? '0 : v;
    endfunction

    function automatic int col_lsb(input int idx, input int bw);
        return idx * bw;
    endfunction

endpackage

// File: rtl/psum_ofifo_col_fifo.sv
// One column of the output collector: circular buffer with wrap-bit pointers.
module col_fifo
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               pop_ok;
    logic               accept;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign pop_ok = pop && !empty;
    // A concurrent pop frees a slot, so a full column still takes the write.
    assign accept = wr && (!full || pop_ok);
    assign drop   = wr && full && !pop_ok;
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// South-edge psum collector: per-column FIFOs realigning skewed array outputs into rows.
// Optional PSUM_OFIFO_RELU_EN applies ReLU to the popped view; stored data stays raw.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] drop;
    logic           pop;
    logic           overflow;

    assign o_valid    = ~|empty;
    assign o_full     = |full;
    assign o_ready    = ~o_full;
    assign pop        = rd && o_valid;
    assign o_overflow = overflow;

    for (genvar gi = 0; gi < col; gi++) begin : g_col
        logic [psum_bw-1:0] head;
        logic [psum_bw-1:0] view;

        col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[gi]),
            .din   (in[col_lsb(gi, psum_bw) +: psum_bw]),
            .pop   (pop),
            .head  (head),
            .empty (empty[gi]),
            .full  (full[gi]),
            .drop  (drop[gi])
        );

`ifdef PSUM_OFIFO_RELU_EN
        assign view = relu(head);
`else
        assign view = head;
`endif
        assign out[col_lsb(gi, psum_bw) +: psum_bw] = o_valid ? view : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      overflow <= 1'b0;
        else if (|drop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomised bench for psum_ofifo against a queue-per-column reference model.
module tb_psum_ofifo;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [BW*COL-1:0] in;
    logic [COL-1:0]   wr;
    logic             rd;
    logic [BW*COL-1:0] out;
    logic             o_valid, o_full, o_ready, o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] q [COL][$];
    logic          m_ovf;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW*COL-1:0] obs, input logic [BW*COL-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] view_of(input logic [BW-1:0] v);
`ifdef PSUM_OFIFO_RELU_EN
        return (v >= 16'h8000) ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic model_valid();
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < COL; i++) if (q[i].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string ctx);
        logic [BW*COL-1:0] exp_out;
        logic              v;
        v = model_valid();
        exp_out = '0;
        if (v) for (int i = 0; i < COL; i++) exp_out[i*BW +: BW] = view_of(q[i][0]);
        chk({ctx, ".valid"}, {127'd0, o_valid}, {127'd0, v});
        chk({ctx, ".full"}, {127'd0, o_full}, {127'd0, model_full()});
        chk({ctx, ".ready"}, {127'd0, o_ready}, {127'd0, !model_full()});
        chk({ctx, ".ovf"}, {127'd0, o_overflow}, {127'd0, m_ovf});
        chk({ctx, ".out"}, out, exp_out);
    endtask

    task automatic model_clear();
        for (int i = 0; i < COL; i++) q[i].delete();
        m_ovf = 1'b0;
    endtask

    task automatic step(input string ctx, input logic [COL-1:0] w, input logic r, input logic [BW*COL-1:0] d);
        logic pop;
        logic was_full [COL];
        wr = w;
        rd = r;
        in = d;
        @(posedge clk);
        pop = r && model_valid();
        for (int i = 0; i < COL; i++) was_full[i] = (q[i].size() == DEP);
        if (pop) for (int i = 0; i < COL; i++) void'(q[i].pop_front());
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (!was_full[i] || pop) q[i].push_back(d[i*BW +: BW]);
                else m_ovf = 1'b1;
            end
        end
        #1;
        check_all(ctx);
    endtask

    function automatic logic [BW*COL-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [BW*COL-1:0] d;
        reset = 1'b1;
        wr = '0;
        rd = 1'b0;
        in = '0;
        model_clear();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 3; k++) step("idle_rd", '0, 1'b1, rnd_row());

        for (int i = 0; i < COL; i++) begin
            d = rnd_row();
            d[i*BW +: BW] = 16'h0100 + BW'(i);
            step("skew", COL'(1) << i, 1'b0, d);
        end
        step("skew_pop", '0, 1'b1, rnd_row());

        for (int k = 0; k < DEP; k++) step("fill3", 8'h08, 1'b0, rnd_row());
        d = rnd_row();
        d[3*BW +: BW] = 16'hDEAD;
        step("ovf3", 8'h08, 1'b0, d);
        for (int k = 0; k < DEP; k++) step("fill_rest", 8'hF7, 1'b0, rnd_row());
        for (int k = 0; k < 10; k++) step("full_rw", 8'hFF, 1'b1, rnd_row());
        for (int k = 0; k < DEP + 2; k++) step("drain", '0, 1'b1, rnd_row());

        for (int k = 0; k < 20; k++) step("pre_rst", 8'hFF, 1'b0, rnd_row());
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst_wr", 8'hFF, 1'b0, rnd_row());
        step("post_rst_idle", '0, 1'b0, rnd_row());
        step("post_rst_pop", '0, 1'b1, rnd_row());

        d = '0;
        d[0*BW +: BW] = 16'hFFF0;
        for (int i = 1; i < COL; i++) d[i*BW +: BW] = 16'h0010;
        step("relu_wr", 8'hFF, 1'b0, d);
        step("relu_pop", '0, 1'b1, rnd_row());

        for (int k = 0; k < 400; k++)
            step("rand", COL'($urandom), 1'($urandom_range(0, 1)), rnd_row());
        for (int k = 0; k < 300; k++)
            step("rand_hi", COL'($urandom) | COL'($urandom), 1'($urandom_range(0, 3) == 0), rnd_row());
        for (int k = 0; k < DEP + 2; k++) step("rand_drain", '0, 1'b1, rnd_row());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector at the south edge of the PE array: receives per-column partial sums and per-column valid strobes from the last MAC row and buffers each column in its own FIFO. Because the array produces skewed results (column i fires one cycle after column i-1), the block realigns them: a full row of psums becomes readable only once every column holds at least one entry. Downstream (SFP / SRAM writeback) pops whole rows with a single read strobe.

## Interface
- col, 8, number of array columns / FIFOs
- psum_bw, 16, width of one partial sum (two's complement)
- depth, 64, entries per column FIFO; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  psum_bw*col  psums from the array's south outputs; column i at bits [psum_bw*(i+1)-1 : psum_bw*i]
- wr  input  col  per-column write strobe, driven by the array's valid vector
- rd  input  1  pop one row from all columns
- out  output  psum_bw*col  head row, same column packing as in
- o_valid  output  1  every column non-empty; out is meaningful
- o_full  output  1  at least one column full
- o_ready  output  1  ~o_full
- o_overflow  output  1  sticky: a write was dropped

## Operation
- Per column: circular buffer, write pointer and read pointer each log2(depth)+1 bits (extra wrap bit). Empty when pointers are equal; full when the low bits are equal and the wrap bits differ.
- Write, column i: accepted when wr[i] and (column not full, or a pop happens in the same cycle). The entry is stored at wptr and wptr increments.
- A write to a full column with no concurrent pop is dropped, and o_overflow sets. o_overflow clears only on reset.
- Pop: when rd && o_valid, every column's rptr increments together.
- rd while !o_valid is ignored: no pointer moves and no error is raised.
- Columns write independently. Skewed arrivals are normal, and pointers may differ between columns.
- out is first-word fall-through: it is the combinational head of each column, forced to all zeros while !o_valid.
- Arithmetic: pointer increments wrap modulo 2*depth. Data is not modified except under the macro below.
- No state machine beyond pointer state. This is plain buffering.

## Timing
- Reset (asynchronous): all pointers 0, o_valid 0, o_full 0, o_ready 1, o_overflow 0, out 0. Memory contents are not reset.
- Write latency: data written at edge t appears on out (with o_valid) from edge t onward, at the earliest the cycle after the strobe. There is no empty-bypass.
- Pop: at the edge where rd && o_valid, the head advances. The next entry, or zeros if a column has become empty, is visible in the following cycle.
- Simultaneous write and pop on a full column: both occur, and the count is unchanged.
- Simultaneous write and pop on a column with one entry: the pop removes the old entry and the new entry becomes head. o_valid stays 1 provided every other column is non-empty.
- Wrap-around: pointers continue through depth-1 → 0 with the wrap bit toggling. Full and empty detection is unaffected.
- Reset asserted mid-stream discards all contents immediately (asynchronously). The first write after deassertion lands at address 0.
- o_full, o_valid and o_ready are combinational from the registered pointers only. They have no path from rd or wr.

## Configuration
- PSUM_OFIFO_RELU_EN defined: each column of out passes through ReLU. A psum with its MSB set reads as 0; otherwise it passes unchanged. Stored data is raw.
- Not defined: out is the raw stored psum.
- Flag and pointer behaviour is identical in both builds.

## Structure
- Package psum_ofifo_pkg holds:
  - the pointer-width function clog2(depth)+1
  - the ReLU function
  - the column-slice helper for psum_bw*col packing
- Sub-module col_fifo implements one column: memory, pointers, empty/full, and the write-accept logic given the external pop.
- psum_ofifo generates col instances of col_fifo, then ANDs the not-empty signals into o_valid and ORs the full signals into o_full.

## Test plan
- Reset then idle → o_valid=0, o_ready=1, out=0. rd pulses move nothing.
- Skewed fill: wr[i] asserted at cycle i (i=0..7) with in column i = 16'h0100+i → o_valid rises the cycle after wr[7]; out reads 0x0100..0x0107; one rd returns o_valid to 0.
- Fill column 3 to 64 entries (others empty) → o_full=1, o_ready=0. A 65th write sets o_overflow, and the dropped value never appears.
- Full FIFOs (all columns at 64) with rd and all wr asserted for 10 cycles → o_full stays 1, no overflow, output order preserved across pointer wrap.
- Reset asserted mid-stream with 20 entries per column → all flags return to reset values immediately. The next row written reads back correctly.
- Build with PSUM_OFIFO_RELU_EN and write 16'hFFF0 and 16'h0010 → out shows 0 and 0x0010. Without the macro, out shows 0xFFF0 and 0x0010.
